// File: rtl/sprite_multicolor_if.sv
// Sprite line-fetch bus between the sprite renderer (master) and the
// line/DMA scheduler plus sprite memory (slave).
//
// Handshake: the master holds `pos` stable while it waits for a grant.
// `dma_avail` is a single-cycle grant for one line read. The slave presents
// the line for `pos` on `data` one cycle after the grant cycle. The master
// captures it in that cycle. There is no back-pressure from the master: a
// grant given while the master is not waiting is simply not used.
//
// Signals:
//   dma_avail  slave->master  memory grant for one line read
//   pos        master->slave  sprite line address
//   data       slave->master  line data, WIDTH*BPP bits
interface sprite_multicolor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
);
  logic                  dma_avail;
  logic [ADDR_WIDTH-1:0] pos;
  logic [DATA_WIDTH-1:0] data;

  modport master (input dma_avail, input data, output pos);
  modport slave  (output dma_avail, output data, input pos);
endinterface

// File: rtl/sprite_multicolor.sv
// Multi-colour hardware sprite renderer. It fetches one sprite line per
// memory grant and renders WIDTH x HEIGHT pixels of BPP bits. Colour index 0
// is transparent. The block supports integer X/Y scaling and a horizontal and
// vertical flip that are latched at draw start.
//
// Ports:
//   pixel_clock  pixel clock
//   reset_n      asynchronous active-low reset
//   start        begin a draw (sampled only in IDLE)
//   flip_x/y     mirror controls, latched with start
//   sx, spr_x    signed current screen x / sprite left edge
//   mem          line-fetch bus (dma_avail, pos, data)
//   pixel_on     opaque pixel being drawn
//   pixel_color  colour index, 0 when not drawing or transparent
//   drawing      FSM is in DRAW
//   done         draw complete, held until the next START
//   state_dbg    current FSM state
module sprite_multicolor #(
  parameter int WIDTH       = 16,
  parameter int HEIGHT      = 16,
  parameter int BPP         = 4,
  parameter int SCALE_X     = 1,
  parameter int SCALE_Y     = 1,
  parameter int LSB_FIRST   = 1,
  parameter int LEAD        = 2,
  parameter int COORD_WIDTH = 16,
  parameter int ADDR_WIDTH  = 9
) (
  input  logic                          pixel_clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          flip_x,
  input  logic                          flip_y,
  input  logic signed [COORD_WIDTH-1:0] sx,
  input  logic signed [COORD_WIDTH-1:0] spr_x,
  sprite_multicolor_if.master           mem,
  output logic                          pixel_on,
  output logic [BPP-1:0]                pixel_color,
  output logic                          drawing,
  output logic                          done,
  output logic [2:0]                    state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_AWAIT_DMA = 3'd2;
  localparam logic [2:0] S_READ_MEM  = 3'd3;
  localparam logic [2:0] S_AWAIT_POS = 3'd4;
  localparam logic [2:0] S_DRAW      = 3'd5;
  localparam logic [2:0] S_NEXT_LINE = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam int OXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int OYW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int CYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  localparam logic [OXW-1:0]        OX_LAST = OXW'(WIDTH - 1);
  localparam logic [OYW-1:0]        OY_LAST = OYW'(HEIGHT - 1);
  localparam logic [CXW-1:0]        CX_LAST = CXW'(SCALE_X - 1);
  localparam logic [CYW-1:0]        CY_LAST = CYW'(SCALE_Y - 1);
  localparam logic [ADDR_WIDTH-1:0] POS_TOP = ADDR_WIDTH'(HEIGHT - 1);

  logic [2:0]            state;
  logic [OXW-1:0]        ox;
  logic [OYW-1:0]        oy;
  logic [CXW-1:0]        cnt_x;
  logic [CYW-1:0]        cnt_y;
  logic                  flip_x_q;
  logic                  flip_y_q;
  logic [ADDR_WIDTH-1:0] pos_r;
  logic [BPP-1:0]        buffer [WIDTH];

  logic                          last_pixel;
  logic                          last_line;
  logic signed [COORD_WIDTH-1:0] trig_x;
  logic [OXW-1:0]                idx;

  assign last_pixel = (ox == OX_LAST) && (cnt_x == CX_LAST);
  assign last_line  = (oy == OY_LAST) && (cnt_y == CY_LAST);
  // Trigger LEAD pixels early so the downstream pipeline lines up with spr_x;
  // the subtraction wraps at COORD_WIDTH like the screen counter does.
  assign trig_x     = spr_x - COORD_WIDTH'(LEAD);
  assign idx        = flip_x_q ? (OX_LAST - ox) : ox;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pos_r    <= '0;
      done     <= 1'b0;
      ox       <= '0;
      oy       <= '0;
      cnt_x    <= '0;
      cnt_y    <= '0;
      flip_x_q <= 1'b0;
      flip_y_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) buffer[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            flip_x_q <= flip_x;
            flip_y_q <= flip_y;
            state    <= S_START;
          end
        end
        S_START: begin
          done  <= 1'b0;
          oy    <= '0;
          cnt_y <= '0;
          pos_r <= flip_y_q ? POS_TOP : '0;
          state <= S_AWAIT_DMA;
        end
        S_AWAIT_DMA: begin
          if (mem.dma_avail) state <= S_READ_MEM;
        end
        S_READ_MEM: begin
          // Store the line in logical pixel order so drawing never cares
          // about the memory packing.
          for (int i = 0; i < WIDTH; i++) begin
            if (LSB_FIRST != 0) buffer[i] <= mem.data[i*BPP +: BPP];
            else                buffer[i] <= mem.data[(WIDTH-1-i)*BPP +: BPP];
          end
          state <= S_AWAIT_POS;
        end
        S_AWAIT_POS: begin
          ox    <= '0;
          cnt_x <= '0;
          if (sx == trig_x) state <= S_DRAW;
        end
        S_DRAW: begin
          if (cnt_x == CX_LAST) begin
            cnt_x <= '0;
            ox    <= ox + 1'b1;
          end else begin
            cnt_x <= cnt_x + 1'b1;
          end
          if (last_pixel) state <= last_line ? S_DONE : S_NEXT_LINE;
        end
        S_NEXT_LINE: begin
          // Vertical scaling repeats the buffered line; only a completed
          // logical line moves pos and needs a new fetch.
          if (cnt_y == CY_LAST) begin
            cnt_y <= '0;
            oy    <= oy + 1'b1;
            pos_r <= flip_y_q ? (pos_r - 1'b1) : (pos_r + 1'b1);
            state <= S_AWAIT_DMA;
          end else begin
            cnt_y <= cnt_y + 1'b1;
            state <= S_AWAIT_POS;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pixel_color = '0;
    if (state == S_DRAW) pixel_color = buffer[idx];
  end

  assign pixel_on  = |pixel_color;
  assign drawing   = (state == S_DRAW);
  assign state_dbg = state;
  assign mem.pos   = pos_r;

endmodule

// File: tb/tb_sprite_multicolor.sv
// Bench for sprite_multicolor. Three instances cover the default
// configuration, a 2-bpp MSB-first 8x4 sprite and a scaled 8x2 sprite. The
// screen x counter free-runs over a 200-pixel line.
module tb_sprite_multicolor;

  localparam int LINE_LEN = 200;
  localparam int SPR_X    = 100;
  localparam int LIMIT    = 20000;

  // ---------------- clock / reset ----------------
  logic pixel_clock = 1'b0;
  logic reset_n;
  always #5 pixel_clock = ~pixel_clock;

  logic start0, start1, start2;
  logic flip_x, flip_y, dma_avail;
  logic signed [15:0] sx, spr_x;

  logic       on0, on1, on2;
  logic [3:0] col0;
  logic [1:0] col1;
  logic [3:0] col2;
  logic       drw0, drw1, drw2;
  logic       done0, done1, done2;
  logic [2:0] st0, st1, st2;

  sprite_multicolor_if #(.DATA_WIDTH(64), .ADDR_WIDTH(9)) m0();
  sprite_multicolor_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) m1();
  sprite_multicolor_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) m2();

  assign m0.dma_avail = dma_avail;
  assign m1.dma_avail = dma_avail;
  assign m2.dma_avail = dma_avail;

  logic [63:0] rom0 [16];
  logic [15:0] rom1 [4];
  logic [31:0] rom2 [2];

  always @(posedge pixel_clock) begin
    m0.data <= rom0[m0.pos[3:0]];
    m1.data <= rom1[m1.pos[1:0]];
    m2.data <= rom2[m2.pos[0]];
  end

  sprite_multicolor u0 (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .start(start0),
    .flip_x(flip_x), .flip_y(flip_y), .sx(sx), .spr_x(spr_x), .mem(m0),
    .pixel_on(on0), .pixel_color(col0), .drawing(drw0), .done(done0),
    .state_dbg(st0)
  );

  sprite_multicolor #(.WIDTH(8), .HEIGHT(4), .BPP(2), .LSB_FIRST(0)) u1 (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .start(start1),
    .flip_x(flip_x), .flip_y(flip_y), .sx(sx), .spr_x(spr_x), .mem(m1),
    .pixel_on(on1), .pixel_color(col1), .drawing(drw1), .done(done1),
    .state_dbg(st1)
  );

  sprite_multicolor #(.WIDTH(8), .HEIGHT(2), .SCALE_X(2), .SCALE_Y(3)) u2 (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .start(start2),
    .flip_x(flip_x), .flip_y(flip_y), .sx(sx), .spr_x(spr_x), .mem(m2),
    .pixel_on(on2), .pixel_color(col2), .drawing(drw2), .done(done2),
    .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int failed = 0;
  int cur_inst = -1;
  int grants = 0;
  logic [31:0] cap_col [$];
  logic [31:0] cap_on  [$];
  logic [31:0] cap_pos [$];
  logic [31:0] cap_sx  [$];
  logic [31:0] exp_q     [$];
  logic [31:0] exp_pos_q [$];
  logic [31:0] exp_sx_q  [$];

  always @(negedge pixel_clock) begin
    case (cur_inst)
      0: begin
        if (drw0) begin
          cap_col.push_back(32'(col0)); cap_on.push_back(32'(on0));
          cap_pos.push_back(32'(m0.pos)); cap_sx.push_back(32'(sx));
        end
        if (st0 == 3'd3) grants <= grants + 1;
      end
      1: begin
        if (drw1) begin
          cap_col.push_back(32'(col1)); cap_on.push_back(32'(on1));
          cap_pos.push_back(32'(m1.pos)); cap_sx.push_back(32'(sx));
        end
        if (st1 == 3'd3) grants <= grants + 1;
      end
      2: begin
        if (drw2) begin
          cap_col.push_back(32'(col2)); cap_on.push_back(32'(on2));
          cap_pos.push_back(32'(m2.pos)); cap_sx.push_back(32'(sx));
        end
        if (st2 == 3'd3) grants <= grants + 1;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pixel_clock);
    #1;
    sx = (sx == 16'(LINE_LEN - 1)) ? 16'sd0 : sx + 16'sd1;
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic logic get_done(input int inst);
    case (inst)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_drawing(input int inst);
    case (inst)
      0: return drw0;
      1: return drw1;
      default: return drw2;
    endcase
  endfunction

  function automatic logic [31:0] get_pos(input int inst);
    case (inst)
      0: return 32'(m0.pos);
      1: return 32'(m1.pos);
      default: return 32'(m2.pos);
    endcase
  endfunction

  // Reference sprite images, by instance, logical line and pixel.
  function automatic int model_pix(input int inst, input int line, input int i);
    if (inst == 0) return (i + line) % 16;
    if (inst == 1) return (line == 0) ? ((i < 4) ? i : 0) : (i + line) % 4;
    return (line == 0) ? i : 15 - i;
  endfunction

  int w_of [3];
  int h_of [3];
  int sxs_of [3];
  int sys_of [3];

  typedef struct {
    int   inst;
    logic fx;
    logic fy;
    logic poke;
    int   exp_cycles;
    int   exp_grants;
    int   exp_final_pos;
  } draw_rec_t;

  draw_rec_t tbl [6];

  task automatic run_draw(input int t);
    draw_rec_t rec;
    int w, h, scx, scy, row_len, n, ncap;
    logic poked;
    rec = tbl[t];
    w = w_of[rec.inst]; h = h_of[rec.inst];
    scx = sxs_of[rec.inst]; scy = sys_of[rec.inst];
    row_len = w * scx;
    cap_col.delete(); cap_on.delete(); cap_pos.delete(); cap_sx.delete();
    exp_q.delete(); exp_pos_q.delete(); exp_sx_q.delete();
    for (int c = 0; c < row_len * h * scy; c++) begin
      int row, k, lrow, line, pidx;
      row  = c / row_len;
      k    = (c % row_len) / scx;
      lrow = row / scy;
      line = rec.fy ? h - 1 - lrow : lrow;
      pidx = rec.fx ? w - 1 - k : k;
      exp_q.push_back(32'(model_pix(rec.inst, line, pidx)));
      exp_pos_q.push_back(32'(line));
      exp_sx_q.push_back(32'(SPR_X - 1 + (c % row_len)));
    end
    grants = 0;
    cur_inst = rec.inst;
    dma_avail = 1'b1;
    flip_x = rec.fx;
    flip_y = rec.fy;
    set_start(rec.inst, 1'b1);
    tick();
    set_start(rec.inst, 1'b0);
    // Flip inputs moving after the latch must not affect this draw.
    flip_x = ~rec.fx;
    flip_y = ~rec.fy;
    tick();
    chk($sformatf("r%0d_done_cleared", t), 32'(get_done(rec.inst)), 0);
    poked = 1'b0;
    n = 0;
    while (!get_done(rec.inst) && n < LIMIT) begin
      if (rec.poke && !poked && get_drawing(rec.inst)) begin
        set_start(rec.inst, 1'b1);
        poked = 1'b1;
      end
      tick();
      set_start(rec.inst, 1'b0);
      n++;
    end
    chk($sformatf("r%0d_timeout", t), 32'(n >= LIMIT), 0);
    chk($sformatf("r%0d_draw_cycles", t), 32'(cap_col.size()), 32'(rec.exp_cycles));
    chk($sformatf("r%0d_grants", t), 32'(grants), 32'(rec.exp_grants));
    chk($sformatf("r%0d_final_pos", t), get_pos(rec.inst), 32'(rec.exp_final_pos));
    ncap = cap_col.size();
    for (int c = 0; c < ncap && exp_q.size() > 0; c++) begin
      logic [32-1:0] e_col;
      e_col = exp_q.pop_front();
      chk($sformatf("r%0d_color[%0d]", t, c), cap_col[c], e_col);
      chk($sformatf("r%0d_on[%0d]", t, c), cap_on[c], 32'(e_col != 0));
      chk($sformatf("r%0d_pos[%0d]", t, c), cap_pos[c], exp_pos_q.pop_front());
      chk($sformatf("r%0d_sx[%0d]", t, c), cap_sx[c], exp_sx_q.pop_front());
    end
    repeat (5) tick();
    chk($sformatf("r%0d_done_held", t), 32'(get_done(rec.inst)), 1);
    chk($sformatf("r%0d_idle_not_drawing", t), 32'(get_drawing(rec.inst)), 0);
    cur_inst = -1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, bad;
    reset_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    flip_x = 1'b0; flip_y = 1'b0; dma_avail = 1'b0;
    sx = 16'sd0; spr_x = 16'(SPR_X);

    w_of = '{16, 8, 8}; h_of = '{16, 4, 2};
    sxs_of = '{1, 1, 2}; sys_of = '{1, 1, 3};

    for (int l = 0; l < 16; l++)
      for (int i = 0; i < 16; i++) rom0[l][i*4 +: 4] = 4'(model_pix(0, l, i));
    rom1[0] = 16'h1B00;
    for (int l = 1; l < 4; l++)
      for (int i = 0; i < 8; i++) rom1[l][(7-i)*2 +: 2] = 2'(model_pix(1, l, i));
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 8; i++) rom2[l][i*4 +: 4] = 4'(model_pix(2, l, i));

    //          inst fx    fy    poke  cycles grants final_pos
    tbl[0] = '{0, 1'b0, 1'b0, 1'b0, 256, 16, 15};
    tbl[1] = '{0, 1'b1, 1'b0, 1'b1, 256, 16, 15};
    tbl[2] = '{1, 1'b0, 1'b1, 1'b0, 32,  4,  0};
    tbl[3] = '{1, 1'b1, 1'b0, 1'b0, 32,  4,  3};
    tbl[4] = '{2, 1'b0, 1'b0, 1'b0, 96,  2,  1};
    tbl[5] = '{2, 1'b0, 1'b1, 1'b0, 96,  2,  0};

    repeat (3) tick();
    chk("rst_color0", 32'(col0), 0);
    chk("rst_on0", 32'(on0), 0);
    chk("rst_drawing0", 32'(drw0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_pos0", 32'(m0.pos), 0);
    chk("rst_state0", 32'(st0), 0);
    chk("rst_state1", 32'(st1), 0);
    chk("rst_state2", 32'(st2), 0);
    reset_n = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) run_draw(t);

    // Grant withheld: the FSM must wait in AWAIT_DMA without drawing.
    dma_avail = 1'b0;
    flip_x = 1'b0;
    flip_y = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      if (st0 !== 3'd2 || drw0 !== 1'b0) bad++;
      tick();
    end
    chk("stall_hold_cycles", 32'(bad), 0);
    chk("stall_state", 32'(st0), 2);
    chk("stall_drawing", 32'(drw0), 0);
    chk("stall_done_cleared", 32'(done0), 0);
    dma_avail = 1'b1;
    tick();
    chk("grant_to_read_mem", 32'(st0), 3);
    tick();
    chk("read_to_await_pos", 32'(st0), 4);

    // Asynchronous reset in the middle of an opaque pixel.
    n = 0;
    while (on0 !== 1'b1 && n < 2 * LINE_LEN) begin
      tick();
      n++;
    end
    chk("mid_draw_reach_timeout", 32'(n >= 2 * LINE_LEN), 0);
    chk("mid_draw_drawing", 32'(drw0), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_color", 32'(col0), 0);
    chk("async_rst_on", 32'(on0), 0);
    chk("async_rst_drawing", 32'(drw0), 0);
    chk("async_rst_state", 32'(st0), 0);
    chk("async_rst_pos", 32'(m0.pos), 0);
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done0 !== 1'b0 || st0 !== 3'd0) bad++;
    end
    chk("no_partial_done", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
